// File: rtl/bitunstuffing.sv
// Serial bit unstuffer: drops the 0 inserted after every RUN_LEN consecutive 1s,
// counts removed bits per packet and flags a 1 found in a stuff slot as an error.
module bitunstuffing #(
    parameter int RUN_LEN = 6
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       bstr_in,
    input  logic [1:0] bstr_in_ready,
    output logic       bstr_out,
    output logic [1:0] bstr_out_ready,
    output logic [5:0] removed,
    output logic       stuff_err,
    output logic       pkt_done
);

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    localparam logic [2:0] RUN_LEN_C = 3'(RUN_LEN);

    state_t     state_q, state_d;
    logic [2:0] ones_q, ones_d;
    logic       out_q, out_d;
    logic [1:0] rdy_q, rdy_d;
    logic [5:0] removed_q, removed_d;
    logic       err_q, err_d;
    logic       done_q, done_d;

    logic in_vld;
    logic stuff_slot;
    logic take;

    assign in_vld     = |bstr_in_ready;
    assign stuff_slot = (ones_q == RUN_LEN_C);

    always_comb begin
        state_d   = state_q;
        ones_d    = ones_q;
        out_d     = 1'b0;
        rdy_d     = 2'b00;
        removed_d = removed_q;
        err_d     = err_q;
        done_d    = 1'b0;
        take      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_vld) begin
                    state_d   = RUN;
                    removed_d = '0;
                    err_d     = 1'b0;
                    take      = 1'b1;
                end
            end
            RUN: begin
                if (in_vld) begin
                    take = 1'b1;
                end else begin
                    state_d = IDLE;
                    ones_d  = '0;
                    done_d  = 1'b1;
                end
            end
            ERR: begin
                // everything after a violation is swallowed until the packet ends
                if (!in_vld) begin
                    state_d = IDLE;
                    ones_d  = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            if (stuff_slot) begin
                if (bstr_in) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    ones_d = '0;
                    if (removed_d != 6'd63) removed_d = removed_d + 6'd1;
                end
            end else begin
                out_d  = bstr_in;
                rdy_d  = bstr_in_ready;
                ones_d = bstr_in ? ones_q + 3'd1 : 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            ones_q    <= '0;
            out_q     <= 1'b0;
            rdy_q     <= 2'b00;
            removed_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            out_q     <= out_d;
            rdy_q     <= rdy_d;
            removed_q <= removed_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign bstr_out       = out_q;
    assign bstr_out_ready = rdy_q;
    assign removed        = removed_q;
    assign stuff_err      = err_q;
    assign pkt_done       = done_q;

endmodule

// File: doc/bitunstuffing.md
BITUNSTUFFING -- requirements
Module: bitunstuffing

Interface
REQ-001 SHALL have parameter RUN_LEN, default 6: number of consecutive 1 bits after which the next bit is a stuffed 0.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_b, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port bstr_in, input, 1: received stuffed serial bit.
REQ-005 SHALL have port bstr_in_ready, input, 2: packet-type code of bstr_in; 2'b00 means no bit this cycle.
REQ-006 SHALL have port bstr_out, output, 1: unstuffed serial bit.
REQ-007 SHALL have port bstr_out_ready, output, 2: packet-type code of bstr_out; 2'b00 means no bit this cycle.
REQ-008 SHALL have port removed, output, 6: count of stuffed bits removed in the current or last packet.
REQ-009 SHALL have port stuff_err, output, 1: stuffing violation detected in the current or last packet.
REQ-010 SHALL have port pkt_done, output, 1: one-cycle pulse marking the end of a packet.

Function
REQ-011 SHALL accept one input bit in every cycle where bstr_in_ready != 2'b00.
REQ-012 SHALL keep a 3-bit run counter ones:
- accepted 1 increments it;
- accepted 0 clears it;
- it is cleared on packet end.
REQ-013 SHALL treat an accepted bit with ones == RUN_LEN as the stuff slot.
REQ-014 SHALL handle a stuff slot holding 0 as follows:
- the bit is dropped;
- ones <= 0;
- removed increments, saturating at 63.
REQ-015 SHALL handle a stuff slot holding 1 as a violation:
- stuff_err <= 1;
- the bit is dropped;
- the FSM enters ERR.
REQ-016 SHALL register every kept bit: bstr_out = bstr_in and bstr_out_ready = bstr_in_ready exactly 1 cycle after acceptance.
REQ-017 SHALL drive bstr_out = 0 and bstr_out_ready = 2'b00 in cycles with no kept bit.
REQ-018 SHALL implement FSM states IDLE, RUN and ERR.
REQ-019 SHALL implement the IDLE -> RUN transition on the first accepted bit, which also:
- clears removed and stuff_err;
- processes that bit normally.
REQ-020 SHALL implement the RUN -> IDLE transition on the first cycle with bstr_in_ready == 2'b00, with pkt_done = 1 on the following cycle.
REQ-021 SHALL, in ERR, discard all accepted bits with no output, and on bstr_in_ready == 2'b00 go to IDLE with a pkt_done pulse the following cycle.
REQ-022 SHALL hold stuff_err and removed from packet end until the next packet start.
REQ-023 SHALL raise no error for a packet ending with ones == RUN_LEN and no stuff bit.
REQ-024 SHALL continue the same packet when the code changes between two nonzero values mid-packet; the output carries the new code.
REQ-025 SHALL output the sixth consecutive 1 normally; only the stuff-slot bit is removed.
REQ-026 SHALL never stall its input and never buffer more than one bit.

Reset
REQ-027 SHALL, while rst_b = 0, immediately force:
- state = IDLE;
- ones = 0;
- bstr_out = 0;
- bstr_out_ready = 2'b00;
- removed = 0;
- stuff_err = 0;
- pkt_done = 0.
REQ-028 SHALL, on reset mid-packet, discard the partial packet; the first bit after release starts a fresh packet and produces no pkt_done for the aborted packet.

Verification
REQ-029 SHALL cover: bits 1,0,1,1,0,0,1,0 with code 2'b10, then 00 -> identical bits out, 1-cycle latency, code 2'b10; removed = 0; pkt_done once.
REQ-030 SHALL cover: 1,1,1,1,1,1,0,1 with code 2'b01 -> output seven 1s; bstr_out_ready = 00 in the cycle for the dropped 0; removed = 1; stuff_err = 0.
REQ-031 SHALL cover: 1,1,1,1,1,1,1,0,1 -> six 1s out; stuff_err = 1 after the seventh bit; no further output; pkt_done after the 00; stuff_err held until the next packet.
REQ-032 SHALL cover: (1x6, 0) twice, then 00 -> twelve 1s out; removed = 2.
REQ-033 SHALL cover: packet ending 1,1,1,1,1, one idle cycle, next packet 1,0 -> no bit removed, because ones was cleared at packet end; two pkt_done pulses.
REQ-034 SHALL cover: rst_b asserted after four bits of a packet -> all outputs 0 immediately; the next packet's removed and run count start from 0.
